// File: rtl/cpu_trace_monitor.sv
// Per-cycle trace capture for the LEGv8 CPU: circular buffer, PC-match trigger, post-trigger window, halt detect.
// Optional macro TRACE_TIMESTAMP_EN adds a free-running 32-bit cycle stamp to every entry.
module cpu_trace_monitor #(
    parameter int DEPTH       = 16,
    parameter int HALT_CYCLES = 4,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          arm,
    input  logic [63:0]   trig_pc,
    input  logic [AW:0]   post_len,
    input  logic [63:0]   counter,
    input  logic [31:0]   instruction,
    input  logic [63:0]   read1,
    input  logic [63:0]   read2,
    input  logic [63:0]   alu_out,
    input  logic [63:0]   mem_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [63:0]   rd_pc,
    output logic [31:0]   rd_inst,
    output logic [63:0]   rd_r1,
    output logic [63:0]   rd_r2,
    output logic [63:0]   rd_alu,
    output logic [63:0]   rd_mem,
    output logic [31:0]   rd_timestamp,
    output logic [1:0]    state,
    output logic          triggered,
    output logic          halted,
    output logic [AW:0]   count
);

    localparam int SW = $clog2(HALT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rem_r, rem_nxt_s, post_clamp_s;
    logic [AW-1:0]   oldest_s, rd_addr_s;
    logic [AW:0]     count_r;
    logic [SW-1:0]   stall_r, stall_nxt_s;
    logic [63:0]     prev_pc_r;
    logic            prev_valid_r;
    logic            triggered_r, halted_r;
    logic            wr_en_s, trig_hit_s, halt_hit_s, rd_hit_s;

    logic [63:0]     pc_mem_r   [DEPTH];
    logic [31:0]     inst_mem_r [DEPTH];
    logic [63:0]     r1_mem_r   [DEPTH];
    logic [63:0]     r2_mem_r   [DEPTH];
    logic [63:0]     alu_mem_r  [DEPTH];
    logic [63:0]     mem_mem_r  [DEPTH];

    // Clamp the requested post-trigger window to what the buffer can hold
    always_comb begin
        if (post_len > (AW+1)'(DEPTH - 1)) begin
            post_clamp_s = AW'(DEPTH - 1);
        end else begin
            post_clamp_s = post_len[AW-1:0];
        end
    end

    // Next-state, write enable, trigger and halt decode
    always_comb begin
        state_nxt_s = state_r;
        rem_nxt_s   = rem_r;
        stall_nxt_s = stall_r;
        wr_en_s     = 1'b0;
        trig_hit_s  = 1'b0;
        halt_hit_s  = 1'b0;
        if (arm) begin
            state_nxt_s = ST_ARMED;
            rem_nxt_s   = post_clamp_s;
            stall_nxt_s = SW'(0);
        end else begin
            case (state_r)
                ST_ARMED, ST_POST: begin
                    wr_en_s = 1'b1;
                    if (prev_valid_r && (counter == prev_pc_r)) begin
                        stall_nxt_s = stall_r + SW'(1);
                    end else begin
                        stall_nxt_s = SW'(0);
                    end
                    halt_hit_s = (stall_nxt_s == SW'(HALT_CYCLES));
                    trig_hit_s = (state_r == ST_ARMED) && (counter == trig_pc);
                    if (halt_hit_s) begin
                        state_nxt_s = ST_DONE;
                    end else if (state_r == ST_ARMED) begin
                        if (trig_hit_s) begin
                            state_nxt_s = (rem_r == AW'(0)) ? ST_DONE : ST_POST;
                        end else begin
                            state_nxt_s = ST_ARMED;
                        end
                    end else begin
                        rem_nxt_s   = rem_r - AW'(1);
                        state_nxt_s = (rem_nxt_s == AW'(0)) ? ST_DONE : ST_POST;
                    end
                end
                default: begin
                    state_nxt_s = state_r;
                end
            endcase
        end
    end

    // Control state, write pointer, occupancy and sticky flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            rem_r        <= AW'(0);
            stall_r      <= SW'(0);
            wr_ptr_r     <= AW'(0);
            count_r      <= (AW+1)'(0);
            triggered_r  <= 1'b0;
            halted_r     <= 1'b0;
            prev_pc_r    <= 64'd0;
            prev_valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            rem_r   <= rem_nxt_s;
            stall_r <= stall_nxt_s;
            if (arm) begin
                wr_ptr_r     <= AW'(0);
                count_r      <= (AW+1)'(0);
                triggered_r  <= 1'b0;
                halted_r     <= 1'b0;
                prev_valid_r <= 1'b0;
            end else if (wr_en_s) begin
                wr_ptr_r     <= wr_ptr_r + AW'(1);
                if (count_r != (AW+1)'(DEPTH)) begin
                    count_r <= count_r + (AW+1)'(1);
                end
                prev_pc_r    <= counter;
                prev_valid_r <= 1'b1;
                triggered_r  <= triggered_r | trig_hit_s;
                halted_r     <= halted_r | halt_hit_s;
            end
        end
    end

    // Trace storage; contents are meaningless until counted as valid
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            pc_mem_r[wr_ptr_r]   <= counter;
            inst_mem_r[wr_ptr_r] <= instruction;
            r1_mem_r[wr_ptr_r]   <= read1;
            r2_mem_r[wr_ptr_r]   <= read2;
            alu_mem_r[wr_ptr_r]  <= alu_out;
            mem_mem_r[wr_ptr_r]  <= mem_data;
        end
    end

    // Logical index 0 is the oldest entry, which sits at wr_ptr once the buffer has wrapped
    always_comb begin
        if (count_r == (AW+1)'(DEPTH)) begin
            oldest_s = wr_ptr_r;
        end else begin
            oldest_s = AW'(0);
        end
        rd_addr_s = oldest_s + rd_idx;
        rd_hit_s  = ({1'b0, rd_idx} < count_r);
    end

    // Registered read port
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_pc    <= 64'd0;
            rd_inst  <= 32'd0;
            rd_r1    <= 64'd0;
            rd_r2    <= 64'd0;
            rd_alu   <= 64'd0;
            rd_mem   <= 64'd0;
        end else if (rd_en) begin
            rd_valid <= rd_hit_s;
            rd_pc    <= rd_hit_s ? pc_mem_r[rd_addr_s]   : 64'd0;
            rd_inst  <= rd_hit_s ? inst_mem_r[rd_addr_s] : 32'd0;
            rd_r1    <= rd_hit_s ? r1_mem_r[rd_addr_s]   : 64'd0;
            rd_r2    <= rd_hit_s ? r2_mem_r[rd_addr_s]   : 64'd0;
            rd_alu   <= rd_hit_s ? alu_mem_r[rd_addr_s]  : 64'd0;
            rd_mem   <= rd_hit_s ? mem_mem_r[rd_addr_s]  : 64'd0;
        end else begin
            rd_valid <= 1'b0;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts_r;
    logic [31:0] ts_mem_r [DEPTH];
    logic [31:0] rd_ts_r;

    // Free-running cycle stamp, deliberately untouched by arm
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_r <= 32'd0;
        end else begin
            ts_r <= ts_r + 32'd1;
        end
    end

    // Timestamp storage alongside the trace fields
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            ts_mem_r[wr_ptr_r] <= ts_r;
        end
    end

    // Timestamp read register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ts_r <= 32'd0;
        end else if (rd_en) begin
            rd_ts_r <= rd_hit_s ? ts_mem_r[rd_addr_s] : 32'd0;
        end else begin
            rd_ts_r <= rd_ts_r;
        end
    end

    assign rd_timestamp = rd_ts_r;
`else
    assign rd_timestamp = 32'd0;
`endif

    assign state     = state_r;
    assign triggered = triggered_r;
    assign halted    = halted_r;
    assign count     = count_r;

endmodule
